// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Brief    : Controller FSM state encodings shared by the controller and the
//            request scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR_OPEN = 2'b11
  } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/elevator_door_timer.sv
`default_nettype none
// ============================================================================
// Module   : elevator_door_timer
// Brief    : Counts door-open cycles and emits a single-cycle T pulse when the
//            door has been open for DOOR_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_door_timer #(
  parameter int DOOR_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic T
);

  localparam int CNT_W = $clog2(DOOR_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DOOR_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fired_q, fired_d;
  logic             t_q, t_d;

  // Next count: cleared outside the door state, re-armed by a hall call at
  // the open floor, otherwise counts up to the last value and holds there.
  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    t_d     = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (restart) begin
      // The restart cycle itself is count 0 of the new window, so the
      // register already holds 1 on the following cycle.
      cnt_d   = CNT_W'(1);
      fired_d = 1'b0;
    end else if (cnt_q == LAST_CNT) begin
      t_d     = ~fired_q;
      fired_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter, one-shot guard and registered T pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
      t_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
      t_q     <= t_d;
    end
  end

  assign T = t_q;

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Brief    : SCAN request scheduler: latches floor calls, tracks the car
//            position and drives UP/DOWN/EQ/T into the controller FSM.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic                floor_arrive,
  input  logic [1:0]          fsm_state,
  output logic                UP,
  output logic                DOWN,
  output logic                EQ,
  output logic                T,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up,
  output logic                fault
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

  fsm_state_e          st;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
  logic                dir_up_q, dir_up_d;
  logic                fault_q, fault_d;
  logic                up_q, up_d;
  logic                down_q, down_d;
  logic                eq_q, eq_d;
  logic                above, below;
  logic                door_en, door_restart;

  assign st = fsm_state_e'(fsm_state);

  // Floor position from crossing pulses; bad pulses saturate and flag a fault.
  always_comb begin
    cur_floor_d = cur_floor_q;
    fault_d     = fault_q;
    if (floor_arrive) begin
      case (st)
        MOVE_UP: begin
          if (cur_floor_q == TOP_FLOOR) fault_d = 1'b1;
          else                          cur_floor_d = cur_floor_q + FLOOR_W'(1);
        end
        MOVE_DOWN: begin
          if (cur_floor_q == '0) fault_d = 1'b1;
          else                   cur_floor_d = cur_floor_q - FLOOR_W'(1);
        end
        default: fault_d = 1'b1;
      endcase
    end
  end

  // Call latch; while stopped the current floor is served, so its bit is
  // cleared and a same-cycle call there is absorbed.
  always_comb begin
    pending_d = pending_q | call_req;
    if (st == IDLE || st == DOOR_OPEN) pending_d[cur_floor_q] = 1'b0;
  end

  // Outstanding work strictly above / below the car's next position.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_W'(i) > cur_floor_d) above = above | pending_d[i];
      if (FLOOR_W'(i) < cur_floor_d) below = below | pending_d[i];
    end
  end

  // SCAN direction choice while idle, and stop requests while moving.
  always_comb begin
    up_d     = 1'b0;
    down_d   = 1'b0;
    eq_d     = 1'b0;
    dir_up_d = dir_up_q;
    case (st)
      IDLE: begin
        if (above && (dir_up_q || !below)) begin
          up_d     = 1'b1;
          dir_up_d = 1'b1;
        end else if (below) begin
          down_d   = 1'b1;
          dir_up_d = 1'b0;
        end
      end
      MOVE_UP:   eq_d = pending_d[cur_floor_d] | ~above;
      MOVE_DOWN: eq_d = pending_d[cur_floor_d] | ~below;
      default:   eq_d = 1'b0;
    endcase
  end

  // Scheduler state and registered command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      fault_q     <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      fault_q     <= fault_d;
      up_q        <= up_d;
      down_q      <= down_d;
      eq_q        <= eq_d;
    end
  end

  assign door_en      = (st == DOOR_OPEN);
  assign door_restart = door_en & call_req[cur_floor_q];

  elevator_door_timer #(
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_door_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (door_en),
    .restart (door_restart),
    .T       (T)
  );

  assign UP        = up_q;
  assign DOWN      = down_q;
  assign EQ        = eq_q;
  assign cur_floor = cur_floor_q;
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Brief    : Closed-loop bench: a simple controller FSM model consumes the
//            scheduler commands; a reference model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;
  import elevator_pkg::*;

  localparam int N  = 8;
  localparam int FW = 3;
  localparam int DC = 16;

  typedef struct packed {
    logic          up;
    logic          dn;
    logic          eq;
    logic          t;
    logic [FW-1:0] fl;
    logic [N-1:0]  pd;
    logic          dir;
    logic          flt;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] call_req = '0;
  logic         floor_arrive = 1'b0;
  logic [1:0]   fsm_state;
  logic         UP, DOWN, EQ, T, dir_up, fault;
  logic [FW-1:0] cur_floor;
  logic [N-1:0] pending;
  logic         force_en = 1'b0;
  logic [1:0]   force_st = IDLE;

  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];

  // reference model state
  bit   m_pend[N];
  int   m_floor;
  bit   m_dir;
  bit   m_flt;
  int   m_start;
  logic [1:0] m_prev;
  int   now = 0;

  elevator_scheduler #(.N_FLOORS(N), .FLOOR_W(FW), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .call_req(call_req), .floor_arrive(floor_arrive),
    .fsm_state(fsm_state), .UP(UP), .DOWN(DOWN), .EQ(EQ), .T(T),
    .cur_floor(cur_floor), .pending(pending), .dir_up(dir_up), .fault(fault)
  );

  always #5 clk = ~clk;

  // Controller FSM stand-in, overridable for out-of-band scenarios.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsm_state <= IDLE;
    else if (force_en) fsm_state <= force_st;
    else case (fsm_state)
      IDLE:              if (UP) fsm_state <= MOVE_UP; else if (DOWN) fsm_state <= MOVE_DOWN;
      MOVE_UP, MOVE_DOWN: if (EQ) fsm_state <= DOOR_OPEN;
      default:           if (T) fsm_state <= IDLE;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Predict the outputs after the coming edge from the rules of operation.
  task automatic model_step(input logic rn, input logic [N-1:0] call, input logic arr,
                            input logic [1:0] st);
    obs_t e;
    int nf, nabove, nbelow, ahead, behind;
    e = '0;
    if (!rn) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_floor = 0; m_dir = 1; m_flt = 0; m_prev = IDLE;
      e.dir = 1'b1;
    end else begin
      nf = m_floor;
      if (arr) begin
        if (st == MOVE_UP && m_floor < N - 1)      nf = m_floor + 1;
        else if (st == MOVE_DOWN && m_floor > 0)  nf = m_floor - 1;
        else                                      m_flt = 1;
      end
      // door window begins on entry or on a call at the open floor
      if (st == DOOR_OPEN && (m_prev != DOOR_OPEN || call[m_floor])) m_start = now;
      e.t = (st == DOOR_OPEN) && (now - m_start == DC - 1);
      for (int i = 0; i < N; i++) if (call[i]) m_pend[i] = 1;
      if (st == IDLE || st == DOOR_OPEN) m_pend[m_floor] = 0;
      m_floor = nf;
      nabove = 0; nbelow = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) begin
        if (i > m_floor) nabove++;
        if (i < m_floor) nbelow++;
      end
      if (st == IDLE) begin
        ahead  = m_dir ? nabove : nbelow;
        behind = m_dir ? nbelow : nabove;
        if (ahead == 0 && behind > 0) m_dir = !m_dir;
        if (ahead > 0 || behind > 0) begin
          e.up = m_dir;
          e.dn = !m_dir;
        end
      end else if (st == MOVE_UP)   e.eq = m_pend[m_floor] || nabove == 0;
      else if (st == MOVE_DOWN)     e.eq = m_pend[m_floor] || nbelow == 0;
      m_prev = st;
      for (int i = 0; i < N; i++) e.pd[i] = m_pend[i];
      e.fl = FW'(m_floor); e.dir = m_dir; e.flt = m_flt;
    end
    exp_q.push_back(e);
    now++;
  endtask

  // arr_mode: 0 none, 1 pulse, 2 travel (random pulse while moving toward a target)
  task automatic step(input logic [N-1:0] call, input int arr_mode);
    logic a;
    @(negedge clk);
    a = (arr_mode == 1) ||
        (arr_mode == 2 && (fsm_state == MOVE_UP || fsm_state == MOVE_DOWN) && !EQ &&
         $urandom_range(0, 1) == 0);
    call_req = call;
    floor_arrive = a;
    model_step(reset_n, call, a, fsm_state);
  endtask

  // mode 0: idle with nothing pending; 1: door open; 2: at floor 5 moving up
  task automatic travel(input int mode, input int max, input string nm);
    bit done = 0;
    for (int k = 0; k < max && !done; k++) begin
      step('0, 2);
      case (mode)
        0: done = (fsm_state == IDLE) && (pending == '0);
        1: done = (fsm_state == DOOR_OPEN);
        default: done = (fsm_state == MOVE_UP) && (cur_floor == FW'(5));
      endcase
    end
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk);
    reset_n = 1'b0; call_req = '0; floor_arrive = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_cmds", {28'd0, UP, DOWN, EQ, T}, 32'd0);
      chk("rst_floor", {29'd0, cur_floor}, 32'd0);
      chk("rst_pend", {24'd0, pending}, 32'd0);
      chk("rst_dir_fault", {30'd0, dir_up, fault}, 32'd2);
    end
    model_step(1'b0, '0, 1'b0, IDLE);
    step('0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_step(1'b1, '0, 1'b0, fsm_state);
  endtask

  // Scoreboard monitor: every edge yields one observed output vector.
  always begin
    obs_t e, g;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {UP, DOWN, EQ, T, cur_floor, pending, dir_up, fault};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got up%b dn%b eq%b t%b fl%0d pd%h dir%b flt%b want up%b dn%b eq%b t%b fl%0d pd%h dir%b flt%b",
                 $time, g.up, g.dn, g.eq, g.t, g.fl, g.pd, g.dir, g.flt,
                 e.up, e.dn, e.eq, e.t, e.fl, e.pd, e.dir, e.flt);
      end
    end
  end

  initial begin
    int k;
    bit seen;
    do_reset(1'b0);

    // call floor 4 from floor 0
    step(8'h10, 0);
    @(posedge clk); #1;
    chk("up_after_call", {31'd0, UP}, 32'd1);
    travel(0, 300, "trip_to_4");
    chk("floor4", {29'd0, cur_floor}, 32'd4);
    chk("dir_up_after_4", {31'd0, dir_up}, 32'd1);

    // calls at 6 and 1: up to 6 first, then down to 1
    step(8'h42, 0);
    travel(0, 600, "trip_6_then_1");
    chk("floor1", {29'd0, cur_floor}, 32'd1);
    chk("dir_down_after_1", {31'd0, dir_up}, 32'd0);

    // call at the current floor while idle is absorbed
    step(8'h02, 0);
    step('0, 0);
    step('0, 0);
    chk("absorb_pend", {24'd0, pending}, 32'd0);
    chk("absorb_cmds", {30'd0, UP, DOWN}, 32'd0);

    // door extension at floor 2: call pulse at count 10
    step(8'h04, 0);
    travel(1, 200, "reach_door_2");
    repeat (9) step('0, 0);
    step(8'h04, 0);
    seen = 0; k = 0;
    while (!seen && k < 40) begin
      step('0, 0);
      k++;
      seen = T;
    end
    chk("restart_T_delay", k, DC);
    travel(0, 300, "leave_2");

    // reset mid-move at floor 5 with calls at 5 and 7
    step(8'ha0, 0);
    travel(2, 300, "reach_5_moving");
    chk("pre_rst_pend", {24'd0, pending}, 32'ha0);
    do_reset(1'b1);

    // stray arrive while idle
    step('0, 1);
    step('0, 0);
    chk("idle_arrive_fault", {31'd0, fault}, 32'd1);
    chk("idle_arrive_floor", {29'd0, cur_floor}, 32'd0);

    // overshoot past the top floor
    step(8'h80, 0);
    travel(0, 400, "trip_to_7");
    force_en = 1'b1; force_st = MOVE_UP;
    step('0, 0);
    step('0, 1);
    force_st = IDLE;
    step('0, 0);
    force_en = 1'b0;
    step('0, 0);
    chk("top_saturate", {29'd0, cur_floor}, 32'd7);
    chk("top_fault", {31'd0, fault}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset(1'b1);
      else if ($urandom_range(0, 399) == 0) step('0, 1);
      else step(($urandom_range(0, 5) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0, 2);
    end

    step('0, 0);
    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
